sd_req_arbiter: RTL and testbench

//  Shares the single hps_io SD block interface (sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_din) between

---
 rtl/sd_req_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_sd_req_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sd_req_arbiter
//  Description : Round-robin sharing of the hps_io SD block interface between
//                NREQ virtual-disk requesters, with ack timeout abort.
//  Revision    : 1.0
// ============================================================================
module sd_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 50000000,
  parameter int GW      = 2
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic [NREQ*32-1:0]   req_lba,
  input  logic [NREQ-1:0]      req_rd,
  input  logic [NREQ-1:0]      req_wr,
  input  logic [NREQ*8-1:0]    req_buff_din,
  output logic [NREQ-1:0]      req_ack,
  output logic [NREQ-1:0]      req_err,
  output logic [31:0]          sd_lba,
  output logic [NREQ-1:0]      sd_rd,
  output logic [NREQ-1:0]      sd_wr,
  input  logic [NREQ-1:0]      sd_ack,
  output logic [7:0]           sd_buff_din,
  output logic                 busy,
  output logic [GW-1:0]        grant_id
);

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_ISSUE    = 3'd1;
  localparam logic [2:0] c_WAIT_ACK = 3'd2;
  localparam logic [2:0] c_XFER     = 3'd3;
  localparam logic [2:0] c_RELEASE  = 3'd4;

  localparam int            c_CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int            c_TMAX_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [c_CW-1:0] c_TMAX = c_CW'(c_TMAX_I);
  localparam bit            c_TMO_EN = (TIMEOUT > 0);

  logic [2:0]       state_q, state_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [GW-1:0]    rr_q, rr_d;
  logic [31:0]      lba_q, lba_d;
  logic             dir_wr_q, dir_wr_d;
  logic [NREQ-1:0]  rd_q, rd_d;
  logic [NREQ-1:0]  wr_q, wr_d;
  logic [NREQ-1:0]  err_q, err_d;
  logic [c_CW-1:0]  cnt_q, cnt_d;

  logic [NREQ-1:0]  w_req;
  logic [NREQ-1:0]  w_gsel;
  logic             w_greq;
  logic             w_gack;
  logic             w_hit;
  logic [GW-1:0]    w_hit_idx;
  logic [GW-1:0]    w_cand;
  logic [31:0]      w_hit_lba;
  logic             w_hit_rd;

  assign w_req  = req_rd | req_wr;
  assign w_greq = |(w_req & w_gsel);
  assign w_gack = |(sd_ack & w_gsel);

  always_comb begin
    w_gsel = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_gsel[i] = (grant_q == GW'(i));
    end
  end

  // Scan from farthest to nearest so the first index after rr wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    w_cand    = '0;
    w_hit_lba = '0;
    w_hit_rd  = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      w_cand = GW'((int'(rr_q) + k) % NREQ);
      if (w_req[w_cand]) begin
        w_hit     = 1'b1;
        w_hit_idx = w_cand;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (w_hit_idx == GW'(i)) begin
        w_hit_lba = req_lba[32*i +: 32];
        w_hit_rd  = req_rd[i];
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= c_IDLE;
      grant_q  <= '0;
      rr_q     <= GW'(NREQ - 1);
      lba_q    <= '0;
      dir_wr_q <= 1'b0;
      rd_q     <= '0;
      wr_q     <= '0;
      err_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      lba_q    <= lba_d;
      dir_wr_q <= dir_wr_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    lba_d    = lba_q;
    dir_wr_d = dir_wr_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    err_d    = '0;
    cnt_d    = cnt_q;
    case (state_q)
      c_IDLE: begin
        if (w_hit) begin
          grant_d  = w_hit_idx;
          lba_d    = w_hit_lba;
          dir_wr_d = ~w_hit_rd;
          state_d  = c_ISSUE;
        end
      end
      c_ISSUE: begin
        rd_d    = dir_wr_q ? '0 : w_gsel;
        wr_d    = dir_wr_q ? w_gsel : '0;
        cnt_d   = '0;
        state_d = c_WAIT_ACK;
      end
      c_WAIT_ACK: begin
        if (w_gack) begin
          rd_d    = '0;
          wr_d    = '0;
          state_d = c_XFER;
        end else if (!w_greq) begin
          rd_d    = '0;
          wr_d    = '0;
          state_d = c_RELEASE;
        end else if (c_TMO_EN && (cnt_q == c_TMAX)) begin
          rd_d    = '0;
          wr_d    = '0;
          err_d   = w_gsel;
          state_d = c_RELEASE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + c_CW'(1);
        end
      end
      c_XFER: begin
        if (!w_gack) begin
          state_d = c_RELEASE;
        end
      end
      c_RELEASE: begin
        // Holding here until withdrawal keeps a held request from a double grant.
        if (!w_greq) begin
          rr_d    = grant_q;
          state_d = c_IDLE;
        end
      end
      default: begin
        rd_d    = '0;
        wr_d    = '0;
        state_d = c_IDLE;
      end
    endcase
  end

  always_comb begin
    busy        = (state_q != c_IDLE);
    req_ack     = (state_q == c_IDLE) ? '0 : (sd_ack & w_gsel);
    req_err     = err_q;
    sd_lba      = lba_q;
    sd_rd       = rd_q;
    sd_wr       = wr_q;
    grant_id    = grant_q;
    sd_buff_din = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q == GW'(i)) begin
        sd_buff_din = req_buff_din[8*i +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sd_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sd_req_arbiter
//  Description : Directed self-checking bench for sd_req_arbiter.
//  Revision    : 1.0
// ============================================================================
module tb_sd_req_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;
  localparam int GW      = 2;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic [NREQ*32-1:0] req_lba;
  logic [NREQ-1:0]   req_rd;
  logic [NREQ-1:0]   req_wr;
  logic [NREQ*8-1:0] req_buff_din;
  logic [NREQ-1:0]   req_ack;
  logic [NREQ-1:0]   req_err;
  logic [31:0]       sd_lba;
  logic [NREQ-1:0]   sd_rd;
  logic [NREQ-1:0]   sd_wr;
  logic [NREQ-1:0]   sd_ack;
  logic [7:0]        sd_buff_din;
  logic              busy;
  logic [GW-1:0]     grant_id;

  int n_cmp = 0;
  int n_err = 0;

  sd_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .GW(GW)) u_dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .req_lba      (req_lba),
    .req_rd       (req_rd),
    .req_wr       (req_wr),
    .req_buff_din (req_buff_din),
    .req_ack      (req_ack),
    .req_err      (req_err),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_din  (sd_buff_din),
    .busy         (busy),
    .grant_id     (grant_id)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // From IDLE with a request pending: one edge to ISSUE, one edge to WAIT_ACK.
  task automatic grant_cycle(input string tag, input int idx, input bit is_wr);
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << idx;
    tick();
    check_val({tag, "_gid"}, 32'(grant_id), 32'(idx));
    check_val({tag, "_busy"}, 32'(busy), 32'd1);
    tick();
    check_val({tag, "_sd_rd"}, 32'(sd_rd), is_wr ? 32'd0 : 32'(oh));
    check_val({tag, "_sd_wr"}, 32'(sd_wr), is_wr ? 32'(oh) : 32'd0);
  endtask

  // From WAIT_ACK: ack pulse through XFER, ends in RELEASE.
  task automatic ack_cycle(input string tag, input int idx);
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << idx;
    sd_ack = oh;
    #1 check_val({tag, "_req_ack"}, 32'(req_ack), 32'(oh));
    tick();
    check_val({tag, "_strobe_drop"}, 32'(sd_rd | sd_wr), 32'd0);
    sd_ack = '0;
    #1 check_val({tag, "_req_ack_low"}, 32'(req_ack), 32'd0);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    req_lba      = '0;
    req_rd       = '0;
    req_wr       = '0;
    req_buff_din = '0;
    sd_ack       = '0;
    repeat (3) tick();
    check_val("rst_sd_rd", 32'(sd_rd), 32'd0);
    check_val("rst_sd_wr", 32'(sd_wr), 32'd0);
    check_val("rst_sd_lba", sd_lba, 32'd0);
    check_val("rst_req_err", 32'(req_err), 32'd0);
    check_val("rst_grant", 32'(grant_id), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    sd_ack = 4'b1111;
    #1 check_val("idle_ack_gate", 32'(req_ack), 32'd0);
    sd_ack = '0;

    // Single read, long ack.
    req_lba[31:0] = 32'h10;
    req_rd = 4'b0001;
    tick();
    check_val("t1_busy", 32'(busy), 32'd1);
    check_val("t1_no_early_strobe", 32'(sd_rd), 32'd0);
    tick();
    check_val("t1_sd_rd", 32'(sd_rd), 32'h1);
    check_val("t1_sd_lba", sd_lba, 32'h10);
    sd_ack = 4'b0001;
    #1 check_val("t1_req_ack", 32'(req_ack), 32'h1);
    tick();
    check_val("t1_strobe_drop", 32'(sd_rd), 32'd0);
    repeat (510) tick();
    check_val("t1_req_ack_hold", 32'(req_ack), 32'h1);
    check_val("t1_lba_hold", sd_lba, 32'h10);
    sd_ack = '0;
    tick();
    check_val("t1_release_busy", 32'(busy), 32'd1);
    req_rd = '0;
    tick();
    check_val("t1_idle_busy", 32'(busy), 32'd0);

    // Round robin: reset rr to NREQ-1, then 0 and 2 held together.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_lba[31:0]  = 32'h100;
    req_lba[95:64] = 32'h200;
    req_rd = 4'b0101;
    grant_cycle("t2_first", 0, 1'b0);
    check_val("t2_lba0", sd_lba, 32'h100);
    ack_cycle("t2_first", 0);
    req_rd = 4'b0100;
    tick();
    grant_cycle("t2_second", 2, 1'b0);
    check_val("t2_lba2", sd_lba, 32'h200);
    req_rd = 4'b0101;
    ack_cycle("t2_second", 2);
    req_rd = 4'b0001;
    tick();
    grant_cycle("t2_third", 0, 1'b0);
    req_rd = '0;
    tick();
    tick();

    // Write from requester 1 with buffer mux.
    req_buff_din[7:0]  = 8'h3C;
    req_buff_din[15:8] = 8'hA5;
    req_wr = 4'b0010;
    grant_cycle("t3", 1, 1'b1);
    check_val("t3_buff_din", 32'(sd_buff_din), 32'hA5);
    ack_cycle("t3", 1);
    req_wr = '0;
    tick();
    check_val("t3_idle", 32'(busy), 32'd0);

    // Timeout on requester 3.
    req_lba[127:96] = 32'hDEAD;
    req_rd = 4'b1000;
    grant_cycle("t4", 3, 1'b0);
    repeat (15) tick();
    check_val("t4_strobe_held", 32'(sd_rd), 32'h8);
    check_val("t4_no_early_err", 32'(req_err), 32'd0);
    tick();
    check_val("t4_strobe_drop", 32'(sd_rd), 32'd0);
    check_val("t4_err_pulse", 32'(req_err), 32'h8);
    tick();
    check_val("t4_err_once", 32'(req_err), 32'd0);
    check_val("t4_release_busy", 32'(busy), 32'd1);
    req_rd = '0;
    tick();
    check_val("t4_idle", 32'(busy), 32'd0);

    // Read and write both set; foreign ack glitch.
    req_rd = 4'b0001;
    req_wr = 4'b0001;
    grant_cycle("t5", 0, 1'b0);
    sd_ack = 4'b0100;
    #1 check_val("t5_glitch_wait", 32'(req_ack), 32'd0);
    tick();
    check_val("t5_glitch_ignored", 32'(sd_rd), 32'h1);
    sd_ack = 4'b0001;
    tick();
    sd_ack = 4'b0101;
    #1 check_val("t5_glitch_xfer", 32'(req_ack), 32'h1);
    sd_ack = '0;
    tick();
    req_rd = '0;
    req_wr = '0;
    tick();
    check_val("t5_idle", 32'(busy), 32'd0);

    // Reset during XFER.
    req_rd = 4'b0100;
    grant_cycle("t6", 2, 1'b0);
    sd_ack = 4'b0100;
    tick();
    reset = 1'b1;
    tick();
    check_val("t6_rst_sd_rd", 32'(sd_rd), 32'd0);
    check_val("t6_rst_sd_wr", 32'(sd_wr), 32'd0);
    check_val("t6_rst_busy", 32'(busy), 32'd0);
    check_val("t6_rst_err", 32'(req_err), 32'd0);
    reset  = 1'b0;
    sd_ack = '0;
    req_rd = '0;
    tick();

    // Withdrawal during WAIT_ACK.
    req_rd = 4'b0010;
    grant_cycle("t7", 1, 1'b0);
    repeat (3) tick();
    req_rd = '0;
    tick();
    check_val("t7_strobe_drop", 32'(sd_rd), 32'd0);
    check_val("t7_no_err", 32'(req_err), 32'd0);
    tick();
    check_val("t7_no_err_late", 32'(req_err), 32'd0);
    check_val("t7_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
